// File: rtl/sram_1rw_ctrl_20x64.sv
// Purpose: single-outstanding host request/response front end for a 1RW SRAM macro, with range check.
// Latency: in-range response valid 3 edges after accept (accept, issue, capture); out-of-range 1 edge.
// Backpressure: req_ready only in IDLE; a response is held stable until rsp_ready, blocking new requests.
//
// Ports:
//   clk0, rst0                          clock, asynchronous active-high reset
//   req_valid/req_ready/req_we/req_addr/req_wdata   host request channel
//   rsp_valid/rsp_ready/rsp_rdata/rsp_err           host response channel
//   csb0/web0/addr0/din0/dout0          1RW macro port (csb0/web0 active low, all registered)
module sram_1rw_ctrl_20x64 #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_WORDS  = 20
) (
    input  logic                  clk0,
    input  logic                  rst0,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  csb0,
    output logic                  web0,
    output logic [ADDR_WIDTH-1:0] addr0,
    output logic [DATA_WIDTH-1:0] din0,
    input  logic [DATA_WIDTH-1:0] dout0
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    // One extra bit so NUM_WORDS == 2**ADDR_WIDTH is representable and never flags an error.
    localparam logic [ADDR_WIDTH:0] NUM_WORDS_W = (ADDR_WIDTH+1)'(NUM_WORDS);

    state_t                 state;
    state_t                 state_nxt;
    logic                   accept;
    logic                   addr_ok;
    logic                   is_wr;
    logic                   is_wr_nxt;
    logic                   csb0_nxt;
    logic                   web0_nxt;
    logic [ADDR_WIDTH-1:0]  addr0_nxt;
    logic [DATA_WIDTH-1:0]  din0_nxt;
    logic                   rsp_valid_nxt;
    logic [DATA_WIDTH-1:0]  rsp_rdata_nxt;
    logic                   rsp_err_nxt;

    assign req_ready = (state == ST_IDLE) && !rst0;
    assign accept    = req_valid && req_ready;
    assign addr_ok   = ({1'b0, req_addr} < NUM_WORDS_W);

    // State and output registers; every macro-side signal comes straight from a flop.
    always_ff @(posedge clk0 or posedge rst0) begin
        if (rst0) begin
            state     <= ST_IDLE;
            is_wr     <= 1'b0;
            csb0      <= 1'b1;
            web0      <= 1'b1;
            addr0     <= '0;
            din0      <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            state     <= state_nxt;
            is_wr     <= is_wr_nxt;
            csb0      <= csb0_nxt;
            web0      <= web0_nxt;
            addr0     <= addr0_nxt;
            din0      <= din0_nxt;
            rsp_valid <= rsp_valid_nxt;
            rsp_rdata <= rsp_rdata_nxt;
            rsp_err   <= rsp_err_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_nxt = addr_ok ? ST_ISSUE : ST_RESP;
                end
            end
            ST_ISSUE: state_nxt = ST_WAIT;
            ST_WAIT:  state_nxt = ST_RESP;
            ST_RESP: begin
                if (rsp_ready) begin
                    state_nxt = ST_IDLE;
                end
            end
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Next values for the registered outputs.
    always_comb begin
        // csb0/web0 default high so the select is low for exactly the ISSUE cycle.
        csb0_nxt      = 1'b1;
        web0_nxt      = 1'b1;
        addr0_nxt     = addr0;
        din0_nxt      = din0;
        is_wr_nxt     = is_wr;
        rsp_valid_nxt = rsp_valid;
        rsp_rdata_nxt = rsp_rdata;
        rsp_err_nxt   = rsp_err;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    if (addr_ok) begin
                        csb0_nxt  = 1'b0;
                        web0_nxt  = ~req_we;
                        addr0_nxt = req_addr;
                        is_wr_nxt = req_we;
                        // Reads leave din0 alone to avoid needless toggling on the macro bus.
                        if (req_we) begin
                            din0_nxt = req_wdata;
                        end
                    end else begin
                        rsp_valid_nxt = 1'b1;
                        rsp_err_nxt   = 1'b1;
                        rsp_rdata_nxt = '0;
                    end
                end
            end
            ST_ISSUE: begin
                // Macro samples the command at the end of ISSUE; only the strobes drop here.
            end
            ST_WAIT: begin
                // dout0 became valid at the previous edge; capture it now.
                rsp_valid_nxt = 1'b1;
                rsp_err_nxt   = 1'b0;
                rsp_rdata_nxt = is_wr ? '0 : dout0;
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_nxt = 1'b0;
                end
            end
            default: begin
            end
        endcase
    end

endmodule
